// File: rtl/cic_interpolator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic_interpolator : N-stage CIC interpolator with a runtime factor R.     |
// | Combs at the input rate, zero-stuffing, integrators at the output rate.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cic_interpolator #(
    parameter int N              = 4,
    parameter int M              = 1,
    parameter int InDataWidth    = 14,
    parameter int OutDataWidth   = 32,
    parameter int InterpCntWidth = 7
) (
    input  logic                           Clk_i,
    input  logic                           Rst_i,
    input  logic [InterpCntWidth-1:0]      InterpFactor_i,
    input  logic signed [InDataWidth-1:0]  Data_i,
    input  logic                           DataNd_i,
    output logic                           Ready_o,
    output logic signed [OutDataWidth-1:0] Data_o,
    output logic                           DataValid_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef logic signed [OutDataWidth-1:0] sample_t;

    localparam logic [InterpCntWidth-1:0] c_ph_one = {{(InterpCntWidth-1){1'b0}}, 1'b1};

    state_t                    state_q;
    logic [InterpCntWidth-1:0] phase_q;
    logic [InterpCntWidth-1:0] r_lat_q;
    sample_t                   dly_q [N][M];
    sample_t                   comb_out_q;
    sample_t                   integ_q [N];

    sample_t                   w_stage_in [N];
    sample_t                   w_comb_out;
    sample_t                   w_acc;
    sample_t                   w_integ_in;
    sample_t                   integ_d [N];
    logic                      w_last;
    logic                      w_accept;
    logic                      w_enable;

    assign w_enable = (state_q == BURST);
    assign w_last   = w_enable && (phase_q == (r_lat_q - c_ph_one));
    assign Ready_o  = (state_q == IDLE) || w_last;
    assign w_accept = DataNd_i && Ready_o;

    // Comb cascade: each stage subtracts its own input delayed by M accepts.
    always_comb begin
        w_acc = {{(OutDataWidth-InDataWidth){Data_i[InDataWidth-1]}}, Data_i};
        for (int i = 0; i < N; i++) begin
            w_stage_in[i] = w_acc;
            w_acc         = w_acc - dly_q[i][M-1];
        end
        w_comb_out = w_acc;
    end

    // Zero-stuffing: only the first output slot of a burst carries the comb value.
    always_comb begin
        w_integ_in = (phase_q == '0) ? comb_out_q : '0;
        integ_d[0] = integ_q[0] + w_integ_in;
        for (int i = 1; i < N; i++) begin
            integ_d[i] = integ_q[i] + integ_q[i-1];
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            r_lat_q     <= '0;
            comb_out_q  <= '0;
            Data_o      <= '0;
            DataValid_o <= 1'b0;
            for (int i = 0; i < N; i++) begin
                integ_q[i] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly_q[i][j] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                comb_out_q <= w_comb_out;
                for (int i = 0; i < N; i++) begin
                    dly_q[i][0] <= w_stage_in[i];
                    for (int j = 1; j < M; j++) begin
                        dly_q[i][j] <= dly_q[i][j-1];
                    end
                end
                r_lat_q <= (InterpFactor_i == '0) ? c_ph_one : InterpFactor_i;
                phase_q <= '0;
                state_q <= BURST;
            end else if (state_q == BURST) begin
                if (w_last) begin
                    state_q <= IDLE;
                end else begin
                    phase_q <= phase_q + c_ph_one;
                end
            end

            // Output takes the freshly updated last stage so the chain delay is N-1.
            if (w_enable) begin
                for (int i = 0; i < N; i++) begin
                    integ_q[i] <= integ_d[i];
                end
                Data_o <= integ_d[N-1];
            end
            DataValid_o <= w_enable;
        end
    end

endmodule
`default_nettype wire

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- N-stage CIC interpolator; counterpart of the team's CicFilter decimator; upsamples a low-rate signed stream by a runtime factor R.
- Combs run at the input rate, a zero-stuffer follows, integrators run at the output rate.
- Sits between the baseband sample source and the DAC/NCO path, on the shared 50 MHz clock.
- Output rate is set by a one-sample-per-clock burst of R samples per accepted input.

Parameters:
- N, 4, number of comb and integrator stages (1..8).
- M, 1, differential delay of each comb (1 or 2).
- InDataWidth, 14, input sample width, signed.
- OutDataWidth, 32, width of every internal register and of Data_o, signed.
- InterpCntWidth, 7, width of InterpFactor_i and of the phase counter.

Ports:
- Clk_i  in  1  system clock; all logic on its rising edge.
- Rst_i  in  1  asynchronous, active-low reset.
- InterpFactor_i  in  InterpCntWidth  interpolation factor R; sampled only when a sample is accepted.
- Data_i  in  InDataWidth  signed input sample.
- DataNd_i  in  1  new-data strobe; qualifies Data_i.
- Ready_o  out  1  block can accept a sample this cycle.
- Data_o  out  OutDataWidth  signed interpolated output (last integrator).
- DataValid_o  out  1  Data_o valid this cycle.

Behaviour:
- Reset (Rst_i low, asynchronous):
  - Clears comb delay lines, comb output register, integrators, phase counter and R latch.
  - State goes to IDLE.
  - Data_o = 0, DataValid_o = 0, Ready_o = 1 from the first clock after release.
  - Reset mid-burst aborts the burst; no further DataValid_o until a new sample is accepted.
- Arithmetic:
  - Data_i is sign-extended to OutDataWidth.
  - All adds and subtracts are two's complement and wrap modulo 2^OutDataWidth; no saturation.
  - Output is unscaled; DC gain is (R·M)^N / R.
  - Integrator wrap is legal as long as OutDataWidth >= InDataWidth + N·ceil(log2(R·M)).
- Accept: a sample is accepted in the cycle where DataNd_i = 1 and Ready_o = 1. DataNd_i with Ready_o = 0 is ignored (sample lost, no error flag).
- On accept (cycle k):
  - Comb cascade is evaluated combinationally from Data_i and the M-deep per-stage delay lines: c_i = c_{i-1} − c_{i-1}[n−M].
  - The result is registered into CombOut and the delay lines shift.
  - R_lat <= InterpFactor_i; R = 0 is treated as 1.
  - Phase counter is set to 0 and the state goes to BURST.
- BURST:
  - Runs R_lat cycles (k+1 .. k+R_lat); integrator enable is 1 in each.
  - Integrator input is CombOut when phase = 0, else 0.
  - Stage update: I_1 <= I_1 + x; I_i <= I_i + I_{i-1} (old value), i = 2..N. All stages share the enable and hold when it is low.
  - Phase increments each cycle.
  - On phase = R_lat−1: if no new accept occurs, go to IDLE.
- Ready_o = 1 in IDLE and in the last BURST cycle (phase = R_lat−1), else 0.
  - Accept in the last BURST cycle starts the next burst in the following cycle, giving gap-free output.
- Output:
  - Data_o <= I_N and DataValid_o <= enable, both registered.
  - Valid samples appear in cycles k+2 .. k+R_lat+1, one per clock.
  - Data_o holds its last value when DataValid_o = 0.
- Impulse delay: the integrator chain adds N−1 output samples of delay; the first nonzero response is the N-th valid output.
- InterpFactor_i changes outside accept cycles have no effect; a burst always uses its latched R.

Test Plan:
- Reset: hold Rst_i low 10 cycles with DataNd_i toggling -> Data_o = 0, DataValid_o = 0, Ready_o = 1; release -> Ready_o = 1, no valid outputs.
- Impulse, N=4, M=1, R=5: accept 1 then 4 zeros back-to-back -> 25 consecutive valids: 0,0,0,1,4,10,20,35,52,68,80,85,80,68,52,35,20,10,4,1,0,... (sum 625).
- DC gain: continuous accepts of 100 with R=5 -> after settling, Data_o = 12500 on every valid; Ready_o high exactly every 5th cycle; DataValid_o never drops.
- Handshake/gaps: DataNd_i pulsed while Ready_o = 0 -> sample dropped, output stream unchanged; sparse accepts 20 cycles apart -> exactly R valids per accept, integrators hold between bursts.
- Runtime R: accept with InterpFactor_i = 3, change it to 7 mid-burst -> burst length 3; next accept -> 7-cycle burst; R = 0 -> 1-cycle bursts, Ready_o continuously 1.
- Reset mid-burst: assert Rst_i at phase 2 of a 5-cycle burst -> outputs clear immediately, no trailing valids; a subsequent impulse reproduces the scenario-2 sequence exactly.
